div_seq_32: RTL and testbench

//  Sequential 32-bit restoring divider for the CPU DIV instruction (quotient -> LO, remainder -> HI).
//  One shared adder_32 instance, used as a subtractor, is reused for every quotient bit; this block is its controller.

---
 rtl/div_seq_32_pkg.sv | 20 ++
 rtl/div_seq_32_adder.sv | 12 +
 rtl/div_seq_32.sv | 160 ++++++++++++++++
 tb/tb_div_seq_32.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_32_pkg.sv
// rtl/div_seq_32_pkg.sv - shared state encodings and constants for the sequential divider
package div_seq_32_pkg;

    localparam int          WIDTH             = 32;
    localparam int          DIV_STEPS         = 32;
    localparam logic [31:0] DIV0_QUOTIENT_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Two's-complement negation, kept apart from the shared subtractor
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/div_seq_32_adder.sv
// rtl/div_seq_32_adder.sv - 32-bit adder with carry in/out, used by the divider as a subtractor
module div_seq_32_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};

endmodule

// File: rtl/div_seq_32.sv
// rtl/div_seq_32.sv - sequential 32-bit restoring divider; signed mode built with DIV_SIGNED_EN
module div_seq_32
    import div_seq_32_pkg::*;
#(
    parameter logic [WIDTH-1:0] DIV0_QUOTIENT = DIV0_QUOTIENT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             ge;
    logic             div_zero;
    logic             accept;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign div_zero = (divisor == '0);
    assign accept   = (state == DIV_IDLE) && start;

    // Partial remainder shifted left by one with the next dividend bit brought in
    assign step_s = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

    div_seq_32_adder u_sub (
        .a         (step_s),
        .b         (~d_reg),
        .carry_in  (1'b1),
        .sum       (diff),
        .carry_out (carry)
    );

    // r_reg[31] is the bit shifted out of step_s: when set, the true 33-bit
    // value exceeds any divisor, so the subtraction always succeeds
    assign ge = r_reg[WIDTH-1] | carry;

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic sq;
    logic sr;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_abs = a_neg ? neg32(dividend) : dividend;
    assign b_abs = b_neg ? neg32(divisor) : divisor;

    // Result sign flags captured with the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            sq <= 1'b0;
            sr <= 1'b0;
        end else if (accept) begin
            sq <= a_neg ^ b_neg;
            sr <= a_neg;
        end
    end

    assign q_fix = sq ? neg32(q_reg) : q_reg;
    assign r_fix = sr ? neg32(r_reg) : r_reg;
`else
    assign a_abs = dividend;
    assign b_abs = divisor;
    assign q_fix = q_reg;
    assign r_fix = r_reg;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = div_zero ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == 5'd0) state_nxt = DIV_FIX;
            DIV_FIX:  state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        busy = (state != DIV_IDLE);
        done = (state == DIV_DONE);
    end

    // Datapath: operand capture, one restoring step per RUN cycle, result write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= 5'd0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        q_reg       <= a_abs;
                        d_reg       <= b_abs;
                        r_reg       <= '0;
                        cnt         <= 5'(DIV_STEPS - 1);
                        div_by_zero <= 1'b0;
                        if (div_zero) begin
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                DIV_RUN: begin
                    if (ge) begin
                        r_reg <= diff;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= step_s;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                end
                DIV_FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_32.sv
// tb/tb_div_seq_32.sv - self-checking bench for div_seq_32 (signed cases with DIV_SIGNED_EN)
module tb_div_seq_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIV_SIGNED_EN
    logic        signed_op;
`endif
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    div_seq_32 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: mathematical quotient/remainder, truncating toward zero when signed
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
            z = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    // Start one divide, scramble operands after the start edge, wait for done.
    // lat is the cycle index of done (cycle 1 = cycle after the start edge), -1 on timeout.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check32({name, " busy@1"}, 32'(busy), 32'd1);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) $display("FAIL %s timeout: no done within 60 cycles, expected done", name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic sgn);
        logic [31:0] eq, er;
        logic        ez;
        int          lat;
        ref_div(a, b, sgn, eq, er, ez);
        run_div(name, a, b, lat);
        check32({name, " lat"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
        check32({name, " q"}, quotient, eq);
        check32({name, " r"}, remainder, er);
        check32({name, " dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    initial begin
        int          lat;
        int          dcount;
        int          dcyc;
        logic [31:0] q4, r4;
        logic [31:0] ra, rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check32("reset busy", 32'(busy), 32'd0);
        check32("reset done", 32'(done), 32'd0);
        check32("reset q", quotient, 32'd0);
        check32("reset r", remainder, 32'd0);
        check32("reset dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        tbl.push_back('{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'hFFFF_FFFE,  b: 32'h8000_0001,  q: 32'd1,          r: 32'h7FFF_FFFD,  z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'd12345,      b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd12345,      z: 1'b1, lat: 1});
        tbl.push_back('{a: 32'd10,         b: 32'd3,          q: 32'd3,          r: 32'd1,          z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'd5,          b: 32'd7,          q: 32'd0,          r: 32'd5,          z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,          z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'h8000_0000,  z: 1'b0, lat: 34});
        tbl.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          z: 1'b0, lat: 34});

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("tbl%0d", i);
            run_div(nm, tbl[i].a, tbl[i].b, lat);
            check32({nm, " lat"}, 32'(lat), 32'(tbl[i].lat));
            check32({nm, " q"}, quotient, tbl[i].q);
            check32({nm, " r"}, remainder, tbl[i].r);
            check32({nm, " dbz"}, 32'(div_by_zero), 32'(tbl[i].z));
        end

        // Starts during RUN (cycle 5) and during DONE (cycle 34) must be ignored
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(posedge clk);
        #1;
        start  = 1'b0;
        dcount = 0;
        dcyc   = -1;
        q4     = 32'd0;
        r4     = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                dcount++;
                if (dcyc < 0) dcyc = c;
                q4 = quotient;
                r4 = remainder;
            end
            start = (c == 5 || c == 34);
            if (start) begin
                dividend = 32'd77;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check32("ignore done count", 32'(dcount), 32'd1);
        check32("ignore done cycle", 32'(dcyc), 32'd34);
        check32("ignore q", q4, 32'd100);
        check32("ignore r", r4, 32'd0);
        check32("ignore idle busy", 32'(busy), 32'd0);

        // Reset in the middle of a divide abandons it
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check32("midrst busy", 32'(busy), 32'd0);
        check32("midrst done", 32'(done), 32'd0);
        check32("midrst q", quotient, 32'd0);
        check32("midrst r", remainder, 32'd0);
        check32("midrst dbz", 32'(div_by_zero), 32'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcount++;
            @(posedge clk);
            #1;
        end
        check32("midrst no done", 32'(dcount), 32'd0);

        // Randomised unsigned divides against the reference
        for (int i = 0; i < 120; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 16));
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            check_model($sformatf("rnd%0d", i), ra, rb, 1'b0);
        end

`ifdef DIV_SIGNED_EN
        signed_op = 1'b1;
        check_model("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check32("s -7/2 q const", quotient, 32'hFFFF_FFFD);
        check32("s -7/2 r const", remainder, 32'hFFFF_FFFF);
        check_model("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        check32("s 7/-2 q const", quotient, 32'hFFFF_FFFD);
        check32("s 7/-2 r const", remainder, 32'd1);
        check_model("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check32("s min/-1 q const", quotient, 32'h8000_0000);
        check_model("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? 32'($signed(32'($urandom_range(0, 20))) - 10) : $urandom;
            check_model($sformatf("srnd%0d", i), ra, rb, 1'b1);
        end
        signed_op = 1'b0;
        check_model("u fff9/2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        check32("u fff9/2 q const", quotient, 32'h7FFF_FFFC);
        check32("u fff9/2 r const", remainder, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
